// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus memory-mapped CYCLE, CONSOLE (FIFO) and HALT registers.
// Optional cycle counter built only when DMEM_CYCLE_CNT_EN is defined.
module dmem_responder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             halt,
    output logic [WIDTH-1:0] halt_code,
    output logic             err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [WIDTH-1:0] ADDR_CYCLE   = {WIDTH{1'b1}} - WIDTH'(15);
    localparam logic [WIDTH-1:0] ADDR_CONSOLE = {WIDTH{1'b1}} - WIDTH'(11);
    localparam logic [WIDTH-1:0] ADDR_HALT    = {WIDTH{1'b1}} - WIDTH'(7);

    // Address decode
    logic          is_ram;
    logic          is_cycle;
    logic          is_console;
    logic          is_halt;
    logic          mapped;
    logic [AW-1:0] ram_idx;

    assign is_ram     = (addr[WIDTH-1:AW+2] == '0);
    assign is_cycle   = (addr == ADDR_CYCLE);
    assign is_console = (addr == ADDR_CONSOLE);
    assign is_halt    = (addr == ADDR_HALT);
    assign mapped     = is_ram | is_cycle | is_console | is_halt;
    assign ram_idx    = addr[AW+1:2];

    // RAM is never cleared; stores complete even while reset is asserted
    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (memwrite && is_ram) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Cycle counter
    logic [WIDTH-1:0] cycle_cnt;
`ifdef DMEM_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + WIDTH'(1);
        end
    end
`else
    assign cycle_cnt = '0;
`endif

    // Console FIFO
    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]    rd_ptr;
    logic [FW-1:0]    wr_ptr;
    logic [FW:0]      count;
    logic [FW:0]      count_next;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             drop;

    function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
        return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
    endfunction

    assign push_req = memwrite & is_console & ~rst;
    assign pop      = out_valid & out_ready;
    assign full     = (count == (FW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign out_data = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (FW+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (FW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count     <= count_next;
            out_valid <= (count_next != '0);
        end
    end

    // Sticky halt and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            halt      <= 1'b0;
            halt_code <= '0;
            err       <= 1'b0;
        end else begin
            if (memwrite && is_halt && (writedata != '0) && !halt) begin
                halt      <= 1'b1;
                halt_code <= writedata;
            end
            if (drop || (memwrite && !mapped)) begin
                err <= 1'b1;
            end
        end
    end

    // Zero-latency load path
    always_comb begin
        readdata = '0;
        if (is_ram) begin
            readdata = ram[ram_idx];
        end else if (is_cycle) begin
            readdata = cycle_cnt;
        end else if (is_console) begin
            readdata = WIDTH'(count);
        end else if (is_halt) begin
            readdata = WIDTH'(halt);
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH, default 64, number of RAM words; power of two, at least 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, console FIFO entries; power of two.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 memwrite  input  1  store request from processor memory stage.
REQ-007 addr  input  WIDTH  byte address (ALU result of memory stage).
REQ-008 writedata  input  WIDTH  store data.
REQ-009 readdata  output  WIDTH  load data, combinational from addr.
REQ-010 out_valid  output  1  console FIFO non-empty.
REQ-011 out_data  output  WIDTH  console FIFO head word.
REQ-012 out_ready  input  1  consumer accepts head when out_valid is high.
REQ-013 halt  output  1  sticky program-halt flag.
REQ-014 halt_code  output  WIDTH  value written with the halt.
REQ-015 err  output  1  sticky flag for access to an unmapped address.

Function
REQ-016 Address map SHALL be: RAM at 0 .. DEPTH*4-1, word-indexed by addr[log2(DEPTH)+1:2], addr[1:0] ignored; CYCLE at 0xFFFF_FFF0; CONSOLE at 0xFFFF_FFF4; HALT at 0xFFFF_FFF8; everything else unmapped.
REQ-017 Loads SHALL be zero-latency: readdata reflects the current addr and current state in the same cycle, with no handshake.
REQ-018 Stores SHALL take effect at the rising edge where memwrite is high; a load of the same address in the next cycle returns the new value.
REQ-019 A read of CYCLE SHALL return the free-running cycle counter, which increments by 1 every cycle and wraps from 2^WIDTH-1 to 0; writes to CYCLE are ignored.
REQ-020 A write to CONSOLE SHALL push writedata into the FIFO; a read of CONSOLE SHALL return the current FIFO occupancy, zero-extended.
REQ-021 The FIFO SHALL pop when out_valid and out_ready are both high; out_data SHALL be the oldest entry.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged and keep order, including when the FIFO is full.
REQ-023 A push to a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set err.
REQ-024 A write of a nonzero value to HALT SHALL set halt and latch halt_code; later HALT writes SHALL be ignored while halt is high. A write of zero to HALT has no effect.
REQ-025 A HALT read SHALL return {WIDTH-1 zeros, halt}.
REQ-026 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored and SHALL set err.
REQ-027 err and halt SHALL stay high until reset.

Reset
REQ-028 While rst is high, the cycle counter, FIFO pointers, occupancy, halt, halt_code and err SHALL clear to 0 at each clock edge; out_valid reads 0 in the cycle after.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 A memwrite coinciding with rst SHALL NOT push to the FIFO, set halt or set err; a RAM write in that cycle still completes.
REQ-031 A reset during a FIFO handshake SHALL discard all FIFO contents.

Configuration
REQ-032 The macro DMEM_CYCLE_CNT_EN SHALL control the cycle counter.
REQ-033 With DMEM_CYCLE_CNT_EN defined, CYCLE behaves per REQ-019.
REQ-034 Without it, no counter is built, CYCLE reads return 0, and CYCLE stays a mapped address: writes are ignored and do not set err.

Verification
REQ-035 RAM store/load: write 0xDEAD_BEEF to 0x0000_0008, then read 0x0000_0008 and 0x0000_000B -> both return 0xDEAD_BEEF.
REQ-036 CYCLE: release reset, read CYCLE in the 10th cycle after reset deasserts -> 9 (counter defined); 0 with the macro undefined.
REQ-037 FIFO full: out_ready=0, write 1..5 to CONSOLE -> CONSOLE reads 4, err=1; then out_ready=1 -> out_data sequence 1,2,3,4, out_valid falls after the 4th pop.
REQ-038 Push/pop when full: FIFO full, out_ready=1 and a CONSOLE write of 9 in the same cycle -> occupancy stays 4, err stays 0, 9 emerges last.
REQ-039 HALT: write 0 to HALT -> halt=0; write 0x2A then 0x55 -> halt=1, halt_code=0x2A; HALT reads 1.
REQ-040 Unmapped/reset: read 0x0001_0000 -> 0; write there -> err=1; assert rst for one cycle -> err=0, halt=0, out_valid=0, RAM word at 0x8 still 0xDEAD_BEEF.
